mole_scheduler: RTL and testbench

Game-round controller for Whack-a-mole. It starts a game on request and samples the free-running LFSR value `rnd` to choose which of 8 moles to raise. It then times each mole's visibility, scores hits from debounced button pulses, counts misses, and ends the game after a fixed number of rounds. It sits between `randomnumbergenerator` (the `rnd` source) and the LED/7-segment display logic (mole LEDs, score, misses).

---
 rtl/mole_scheduler_if.sv | 14 +
 rtl/mole_scheduler.sv | 113 +++++++++++
 tb/tb_mole_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: game control, random source, buttons and display outputs of the mole scheduler
interface mole_scheduler_if;
  logic       start;
  logic [9:0] rnd;
  logic [7:0] btn;
  logic [7:0] mole;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] round_cnt;
  logic       busy;
  logic       done;
  modport master (output start, rnd, btn, input mole, score, misses, round_cnt, busy, done);
  modport slave (input start, rnd, btn, output mole, score, misses, round_cnt, busy, done);
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round controller (WAM_PENALTY_EN: wrong presses count as misses)
module mole_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int UP_TICKS = 16,
  parameter int GAP_TICKS = 4,
  parameter int ROUNDS = 32,
  parameter int REROLL_MAX = 4
) (
  input logic clk,
  input logic reset,
  mole_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PICK, UP, GAP, DONE} state_t;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TM = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW = (TM > 1) ? $clog2(TM) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] UP_MAX = TW'(UP_TICKS - 1);
  localparam logic [TW-1:0] GAP_MAX = TW'(GAP_TICKS - 1);
  localparam logic [7:0] ROUND_N = 8'(ROUNDS);
  localparam logic [7:0] REROLL_N = 8'(REROLL_MAX);
  localparam logic [3:0] WAIT_N = 4'd9;
  state_t state;
  logic [PW-1:0] pre;
  logic [TW-1:0] tk;
  logic [7:0] reroll;
  logic [3:0] wait_cnt;
  logic [2:0] last_idx;
  logic tick, accept, hit, wrong;
  logic [2:0] pick_idx;
  logic [7:0] rc_next;
  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    return v + {7'd0, ~&v};
  endfunction
  // Tick detection, mole choice (forced neighbour after too many rerolls) and press classification
  always_comb begin
    tick = pre == PRE_MAX;
    accept = reroll == REROLL_N || bus.rnd[2:0] != last_idx || bus.round_cnt == 8'd0;
    pick_idx = reroll == REROLL_N ? last_idx + 3'd1 : bus.rnd[2:0];
    hit = |(bus.btn & bus.mole);
`ifdef WAM_PENALTY_EN
    wrong = |(bus.btn & ~bus.mole);
`else
    wrong = 1'b0;
`endif
    rc_next = inc_sat(bus.round_cnt);
  end
  // Game FSM with registered outputs; prescaler and tick counter restart on every UP/GAP entry
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pre <= '0;
      tk <= '0;
      reroll <= 8'd0;
      wait_cnt <= 4'd0;
      last_idx <= 3'd0;
      bus.mole <= 8'd0;
      bus.score <= 8'd0;
      bus.misses <= 8'd0;
      bus.round_cnt <= 8'd0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= PICK;
          bus.busy <= 1'b1;
          bus.score <= 8'd0;
          bus.misses <= 8'd0;
          bus.round_cnt <= 8'd0;
          reroll <= 8'd0;
          wait_cnt <= 4'd0;
        end
        PICK: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        else if (accept) begin
          state <= UP;
          last_idx <= pick_idx;
          bus.mole <= 8'd1 << pick_idx;
          reroll <= 8'd0;
          pre <= '0;
          tk <= '0;
        end else begin
          reroll <= reroll + 8'd1;
          wait_cnt <= WAIT_N;
        end
        UP: if (hit || wrong || (tick && tk == UP_MAX)) begin
          state <= GAP;
          bus.mole <= 8'd0;
          pre <= '0;
          tk <= '0;
          if (hit) bus.score <= inc_sat(bus.score);
          else bus.misses <= inc_sat(bus.misses);
        end else begin
          pre <= tick ? '0 : pre + 1'b1;
          tk <= tick ? tk + 1'b1 : tk;
        end
        GAP: if (tick && tk == GAP_MAX) begin
          bus.round_cnt <= rc_next;
          state <= rc_next == ROUND_N ? DONE : PICK;
          bus.done <= rc_next == ROUND_N;
        end else begin
          pre <= tick ? '0 : pre + 1'b1;
          tk <= tick ? tk + 1'b1 : tk;
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: randomized game-level bench against a round-by-round reference model
module tb_mole_scheduler;
  localparam int TD = 4, UT = 3, GT = 2, RN = 2, RM = 4;
  localparam int UP_LEN = TD * UT, GAP_LEN = TD * GT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0, n_chk = 0;
  int last = 0, exp_score = 0, exp_miss = 0;
  bit pen;
  always #5 clk = ~clk;
  mole_scheduler_if bus();
  mole_scheduler #(.TICK_DIV(TD), .UP_TICKS(UT), .GAP_TICKS(GT), .ROUNDS(RN), .REROLL_MAX(RM))
    dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_mole"}, bus.mole, 0);
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_misses"}, bus.misses, 0);
    check({tag, "_rounds"}, bus.round_cnt, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask
  // act: 0 no press, 1 correct, 2 wrong bit, 3 both; p: visible cycle of the press
  task automatic play_round(input int rd, input int f_act, input int f_p, input bit f_rep);
    int r, exp_idx, exp_pick, act, p, wbit, exp_up, n, u, g;
    bit acc, hit;
    r = (rd > 0 && (f_rep || $urandom_range(0, 2) == 0)) ? last : int'($urandom_range(0, 7));
    bus.rnd = {7'($urandom), 3'(r)};
    acc = rd == 0 || r != last;
    exp_idx = acc ? r : (last + 1) % 8;
    exp_pick = acc ? 1 : 1 + 10 * RM;
    n = 0;
    do begin
      step;
      n++;
    end while (bus.mole == 0 && n < 100);
    check("pick_len", n, exp_pick);
    check("mole", bus.mole, 1 << exp_idx);
    last = exp_idx;
    act = f_act >= 0 ? f_act : int'($urandom_range(0, 3));
    p = f_p > 0 ? f_p : int'($urandom_range(1, UP_LEN));
    wbit = (exp_idx + int'($urandom_range(1, 7))) % 8;
    hit = act == 1 || act == 3;
    exp_up = (hit || (pen && act == 2)) ? p : UP_LEN;
    if (hit) exp_score++;
    else exp_miss++;
    for (u = 1; u <= UP_LEN + 5; u++) begin
      bus.btn = (u != p) ? 8'h00 : (hit ? 8'(1 << exp_idx) : 8'h00) | (act >= 2 ? 8'(1 << wbit) : 8'h00);
      bus.start = 1'($urandom_range(0, 1));
      step;
      bus.btn = 8'h00;
      bus.start = 1'b0;
      if (bus.mole == 0) break;
    end
    check("up_len", u, exp_up);
    check("score_up", bus.score, exp_score);
    check("misses_up", bus.misses, exp_miss);
    check("rounds_up", bus.round_cnt, rd);
    for (g = 1; g <= GAP_LEN + 5; g++) begin
      bus.btn = 8'($urandom);
      bus.start = 1'($urandom_range(0, 1));
      step;
      if (bus.round_cnt != rd) break;
    end
    bus.btn = 8'h00;
    bus.start = 1'b0;
    check("gap_len", g, GAP_LEN);
    check("rounds_gap", bus.round_cnt, rd + 1);
    check("score_gap", bus.score, exp_score);
    check("misses_gap", bus.misses, exp_miss);
  endtask
  task automatic play_game(input int f_act, input int f_p, input bit f_rep);
    exp_score = 0;
    exp_miss = 0;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_mole", bus.mole, 0);
    check("start_score", bus.score, 0);
    check("start_misses", bus.misses, 0);
    check("start_rounds", bus.round_cnt, 0);
    for (int rd = 0; rd < RN; rd++) play_round(rd, rd == 0 ? f_act : -1, rd == 0 ? f_p : 0, f_rep);
    check("done_pulse", bus.done, 1);
    check("done_busy", bus.busy, 1);
    step;
    check("done_low", bus.done, 0);
    check("busy_low", bus.busy, 0);
    repeat (3) step;
    check("idle_done", bus.done, 0);
    check("idle_score", bus.score, exp_score);
    check("idle_misses", bus.misses, exp_miss);
    check("idle_rounds", bus.round_cnt, RN);
  endtask
  initial begin
    int seen, d;
`ifdef WAM_PENALTY_EN
    pen = 1'b1;
`else
    pen = 1'b0;
`endif
    bus.start = 1'b0;
    bus.btn = 8'h00;
    bus.rnd = 10'd0;
    repeat (3) step;
    check_zero("reset");
    reset = 1'b0;
    seen = 0;
    repeat (50) begin
      step;
      if (bus.mole != 0 || bus.busy || bus.done) seen++;
    end
    check("idle_quiet", seen, 0);
    check_zero("idle");
    play_game(1, 3, 1'b0);
    play_game(1, UP_LEN, 1'b1);
    play_game(2, 3, 1'b0);
    play_game(0, 0, 1'b1);
    bus.rnd = {7'($urandom), 3'd3};
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    step;
    step;
    check("pre_reset_mole", bus.mole, 8'h08);
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    step;
    reset = 1'b0;
    d = 0;
    repeat (10) begin
      step;
      d += int'(bus.done) + int'(bus.busy);
    end
    check("post_reset_quiet", d, 0);
    play_game(-1, 0, 1'b0);
    repeat (20) play_game(-1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
